// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch/align path.
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned HW_W = 16;
    localparam logic [1:0]  OPC_FULL = 2'b11;

    typedef logic [HW_W-1:0] hword_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    // A halfword starts a 16-bit instruction unless its low opcode bits are 2'b11.
    function automatic logic hw_is_comp(input hword_t h);
        return h[1:0] != OPC_FULL;
    endfunction

endpackage

// File: rtl/fetch_align_buffer_if.sv
// Redirect, instruction-memory and aligned-instruction signals of the fetch unit.
interface fetch_align_buffer_if;
    import fetch_pkg::*;

    logic            flush;
    logic [XLEN-1:0] redirect_pc;
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_out;
    logic [XLEN-1:0] inst_pc;
    logic            inst_is_comp;

    modport master (
        input  flush, redirect_pc, mem_rvalid, mem_rdata, inst_ready,
        output mem_req, mem_addr, inst_valid, inst_out, inst_pc, inst_is_comp
    );

    modport slave (
        output flush, redirect_pc, mem_rvalid, mem_rdata, inst_ready,
        input  mem_req, mem_addr, inst_valid, inst_out, inst_pc, inst_is_comp
    );

endinterface

// File: rtl/fetch_hw_queue.sv
// Four-entry halfword FIFO accepting and releasing up to two halfwords per cycle.
module fetch_hw_queue
    import fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic [1:0] push_n,
    input  hword_t     push_d0,
    input  hword_t     push_d1,
    input  logic [1:0] pop_n,
    output hword_t     head,
    output hword_t     head1,
    output logic [2:0] count
);

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;

    hword_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;

    assign head  = mem[rd_ptr];
    assign head1 = mem[rd_ptr + PTR_W'(1)];

    // push_d0 lands first; the caller never pushes past four entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_n != 2'd0) mem[wr_ptr] <= push_d0;
            if (push_n == 2'd2) mem[wr_ptr + PTR_W'(1)] <= push_d1;
            wr_ptr <= wr_ptr + PTR_W'(push_n);
            rd_ptr <= rd_ptr + PTR_W'(pop_n);
            count  <= count + 3'(push_n) - 3'(pop_n);
        end
    end

endmodule

// File: rtl/fetch_align_buffer.sv
// Fetches 32-bit words, buffers halfwords and presents aligned 16/32-bit instructions.
module fetch_align_buffer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_align_buffer_if.master bus
);

    fetch_state_e    state;
    fetch_state_e    state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_pc_nxt;
    logic            skip_hw;
    logic            skip_hw_nxt;
    logic [XLEN-1:0] inst_pc;
    logic            mem_req_c;
    logic [1:0]      push_n;
    logic [1:0]      pop_n;
    hword_t          head;
    hword_t          head1;
    logic [2:0]      count;
    logic            head_comp;
    logic            avail;
    logic            out_valid;

    fetch_hw_queue u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (bus.flush),
        .push_n  (push_n),
        .push_d0 (skip_hw ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0]),
        .push_d1 (bus.mem_rdata[31:16]),
        .pop_n   (pop_n),
        .head    (head),
        .head1   (head1),
        .count   (count)
    );

    // Zero-latency output path straight off the queue head
    assign head_comp = hw_is_comp(head);
    assign avail     = (count >= 3'd2) || ((count != 3'd0) && head_comp);
    assign out_valid = avail && !bus.flush;

    assign bus.inst_valid   = out_valid;
    assign bus.inst_is_comp = out_valid && head_comp;
    assign bus.inst_out     = !out_valid ? '0
                            : head_comp  ? {HW_W'(0), head}
                            :              {head1, head};
    assign bus.inst_pc      = inst_pc;
    assign bus.mem_addr     = fetch_pc;
    assign bus.mem_req      = mem_req_c && rst_n;

    assign pop_n = (out_valid && bus.inst_ready) ? (head_comp ? 2'd1 : 2'd2) : 2'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= {RESET_PC[31:2], 2'b00};
            skip_hw  <= RESET_PC[1];
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            skip_hw  <= skip_hw_nxt;
        end
    end

    // Request only while two free slots remain, so a returning word always fits
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        skip_hw_nxt  = skip_hw;
        mem_req_c    = 1'b0;
        push_n       = 2'd0;
        unique case (state)
            IDLE: begin
                if (!bus.flush && (count <= 3'd2)) begin
                    mem_req_c = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.flush) begin
                    state_nxt = bus.mem_rvalid ? IDLE : DROP;
                end else if (bus.mem_rvalid) begin
                    push_n       = skip_hw ? 2'd1 : 2'd2;
                    skip_hw_nxt  = 1'b0;
                    fetch_pc_nxt = fetch_pc + XLEN'(4);
                    state_nxt    = IDLE;
                end
            end
            DROP: begin
                if (bus.mem_rvalid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.flush) begin
            fetch_pc_nxt = bus.redirect_pc & ~XLEN'(3);
            skip_hw_nxt  = bus.redirect_pc[1];
        end
    end

    // Address of the instruction at the queue head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_pc <= {RESET_PC[31:1], 1'b0};
        end else if (bus.flush) begin
            inst_pc <= bus.redirect_pc & ~XLEN'(1);
        end else if (pop_n != 2'd0) begin
            inst_pc <= inst_pc + XLEN'({pop_n, 1'b0});
        end
    end

endmodule
